// File: rtl/dbg_capture_ctrl.sv
// ---------------------------------------------------------------------------
// dbg_capture_ctrl
//
// Capture sequencer for the debug RAM (RAM_DEPTH x DATA_WIDTH, 1R1W).
// Capture writes qualified ADC samples into the RAM as a circular
// pre-trigger buffer. It accepts one trigger, writes cfg_post_len further
// samples, and then stops. Readout streams the stored window out oldest-first,
// one sample per rd_req.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cfg_arm           pulse: restart capture (latches cfg_post_len)
//   cfg_abort         pulse: return to IDLE (wins over cfg_arm)
//   cfg_post_len      post-trigger sample count
//   smp_vld/data/trig qualified sample stream; the trigger counts only with smp_vld
//   sts_state         0=IDLE 1=PRE 2=POST 3=DONE (FSM debug view)
//   sts_wrapped       write pointer has wrapped since arm
//   sts_trig_addr     RAM address of the trigger sample
//   rd_req            pulse: fetch the next stored sample (DONE only)
//   rd_busy           a read is outstanding
//   rd_vld/data/last  registered read result; rd_last marks the final sample
//   ram_csa/wra/addra/dina   RAM write port (registered)
//   ram_csb/rdb/addrb        RAM read port (registered)
//   ram_doutb         RAM read data, READ_LATENCY cycles after the read command
//
// Handshake: rd_req is a single-cycle request. It is accepted only when
// rd_busy=0, the state is DONE and samples remain. Accepting a request raises
// rd_busy. rd_busy drops in the same cycle that rd_vld pulses.
// ---------------------------------------------------------------------------
module dbg_capture_ctrl #(
    parameter int RAM_DEPTH    = 4096,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_arm,
    input  logic                  cfg_abort,
    input  logic [ADDR_WIDTH-1:0] cfg_post_len,
    input  logic                  smp_vld,
    input  logic [DATA_WIDTH-1:0] smp_data,
    input  logic                  smp_trig,
    output logic [1:0]            sts_state,
    output logic                  sts_wrapped,
    output logic [ADDR_WIDTH-1:0] sts_trig_addr,
    input  logic                  rd_req,
    output logic                  rd_busy,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  ram_csa,
    output logic                  ram_wra,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_csb,
    output logic                  ram_rdb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX   = ADDR_WIDTH'(RAM_DEPTH - 1);

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   post_len_q;
    logic [ADDR_WIDTH-1:0]   post_cnt;
    logic                    wrapped;
    logic [ADDR_WIDTH-1:0]   trig_addr;

    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH:0]     rd_left;      // samples not yet issued
    logic                    cmd_last;     // last flag travelling with ram_csb
    logic [READ_LATENCY-1:0] rd_pipe;      // read command delay line
    logic [READ_LATENCY-1:0] last_pipe;

    logic                    wr_en;
    logic                    trig_hit;
    logic                    drop;
    logic                    rd_issue;
    logic [ADDR_WIDTH-1:0]   wr_ptr_n;
    logic                    wrapped_n;

    assign sts_state     = state;
    assign sts_wrapped   = wrapped;
    assign sts_trig_addr = trig_addr;

    // Both arm and abort discard any read in flight, so a stale sample from
    // the previous window can never appear after a restart.
    assign drop     = cfg_arm | cfg_abort;
    assign rd_issue = rd_req & ~rd_busy & (state == S_DONE) &
                      (rd_left != '0) & ~drop;

    // Post-write pointer and wrap flag. These values define the stored window
    // when DONE is entered in the same cycle as the final write.
    assign wr_ptr_n  = wr_en ? wr_ptr + PTR_ONE : wr_ptr;
    assign wrapped_n = wrapped | (wr_en & (wr_ptr == PTR_MAX));

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_n  = state;
        wr_en    = 1'b0;
        trig_hit = 1'b0;
        if (cfg_abort) begin
            state_n = S_IDLE;
        end else if (cfg_arm) begin
            state_n = S_PRE;
        end else begin
            case (state)
                S_PRE: begin
                    if (smp_vld) begin
                        wr_en = 1'b1;
                        if (smp_trig) begin
                            trig_hit = 1'b1;
                            state_n  = (post_len_q == '0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (smp_vld) begin
                        wr_en = 1'b1;
                        if (post_cnt == PTR_ONE) state_n = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // ------------------------------------------------------- capture path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            post_len_q <= '0;
            post_cnt   <= '0;
            wrapped    <= 1'b0;
            trig_addr  <= '0;
            ram_csa    <= 1'b0;
            ram_wra    <= 1'b0;
            ram_addra  <= '0;
            ram_dina   <= '0;
        end else begin
            ram_csa <= wr_en;
            ram_wra <= wr_en;
            if (wr_en) begin
                ram_addra <= wr_ptr;
                ram_dina  <= smp_data;
            end
            if (cfg_abort) begin
                // The window bookkeeping stays readable after an abort.
            end else if (cfg_arm) begin
                wr_ptr     <= '0;
                wrapped    <= 1'b0;
                trig_addr  <= '0;
                post_len_q <= cfg_post_len;
            end else begin
                wr_ptr  <= wr_ptr_n;
                wrapped <= wrapped_n;
                if (trig_hit) begin
                    trig_addr <= wr_ptr;
                    post_cnt  <= post_len_q;
                end else if (wr_en && state == S_POST) begin
                    post_cnt <= post_cnt - PTR_ONE;
                end
            end
        end
    end

    // ---------------------------------------------------------- read path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            rd_left   <= '0;
            cmd_last  <= 1'b0;
            rd_pipe   <= '0;
            last_pipe <= '0;
            rd_busy   <= 1'b0;
            rd_vld    <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
            ram_csb   <= 1'b0;
            ram_rdb   <= 1'b0;
            ram_addrb <= '0;
        end else begin
            ram_csb <= rd_issue;
            ram_rdb <= rd_issue;

            // Readout restarts from the oldest sample on every entry to DONE.
            if (state_n == S_DONE && state != S_DONE) begin
                rd_ptr  <= wrapped_n ? wr_ptr_n : '0;
                rd_left <= wrapped_n ? DEPTH_CNT : {1'b0, wr_ptr_n};
            end else if (rd_issue) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_left <= rd_left - CNT_ONE;
            end

            if (rd_issue) begin
                ram_addrb <= rd_ptr;
                cmd_last  <= (rd_left == CNT_ONE);
            end

            // rd_pipe[i] is high in the cycle i+1 after ram_csb. The top stage
            // marks the cycle in which ram_doutb carries the requested word.
            rd_pipe[0]   <= ram_csb & ~drop;
            last_pipe[0] <= cmd_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i]   <= rd_pipe[i-1] & ~drop;
                last_pipe[i] <= last_pipe[i-1];
            end

            rd_vld  <= rd_pipe[READ_LATENCY-1] & ~drop;
            rd_last <= rd_pipe[READ_LATENCY-1] & last_pipe[READ_LATENCY-1] & ~drop;
            if (rd_pipe[READ_LATENCY-1] && !drop) rd_data <= ram_doutb;

            if (drop)                                rd_busy <= 1'b0;
            else if (rd_issue)                       rd_busy <= 1'b1;
            else if (rd_pipe[READ_LATENCY-1])        rd_busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dbg_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dbg_capture_ctrl
//
// Directed bench for dbg_capture_ctrl with a behavioural 4096x16 RAM that has
// a one-cycle read latency. Inputs change 1 ns after each rising edge, and
// outputs are observed at that same point, so each tick() shows the
// registered response to the inputs of the previous cycle.
// ---------------------------------------------------------------------------
module tb_dbg_capture_ctrl;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_arm = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [AW-1:0] cfg_post_len = '0;
    logic          smp_vld = 1'b0;
    logic [DW-1:0] smp_data = '0;
    logic          smp_trig = 1'b0;
    logic [1:0]    sts_state;
    logic          sts_wrapped;
    logic [AW-1:0] sts_trig_addr;
    logic          rd_req = 1'b0;
    logic          rd_busy;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          ram_csa, ram_wra, ram_csb, ram_rdb;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DW-1:0] ram_dina;
    logic [DW-1:0] ram_doutb = '0;

    logic [DW-1:0] mem [0:4095];

    int n_cmp = 0;
    int n_err = 0;

    logic any_out;
    assign any_out = |{sts_state, sts_wrapped, sts_trig_addr, rd_busy, rd_vld,
                       rd_data, rd_last, ram_csa, ram_wra, ram_addra, ram_dina,
                       ram_csb, ram_rdb, ram_addrb};

    always #5 clk = ~clk;

    dbg_capture_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_arm       (cfg_arm),
        .cfg_abort     (cfg_abort),
        .cfg_post_len  (cfg_post_len),
        .smp_vld       (smp_vld),
        .smp_data      (smp_data),
        .smp_trig      (smp_trig),
        .sts_state     (sts_state),
        .sts_wrapped   (sts_wrapped),
        .sts_trig_addr (sts_trig_addr),
        .rd_req        (rd_req),
        .rd_busy       (rd_busy),
        .rd_vld        (rd_vld),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .ram_csa       (ram_csa),
        .ram_wra       (ram_wra),
        .ram_addra     (ram_addra),
        .ram_dina      (ram_dina),
        .ram_csb       (ram_csb),
        .ram_rdb       (ram_rdb),
        .ram_addrb     (ram_addrb),
        .ram_doutb     (ram_doutb)
    );

    // Behavioural RAM, read latency 1
    always @(posedge clk) begin
        if (ram_csa && ram_wra) mem[ram_addra] <= ram_dina;
        if (ram_csb && ram_rdb) ram_doutb <= mem[ram_addrb];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input logic [AW-1:0] len);
        cfg_arm      = 1'b1;
        cfg_post_len = len;
        tick();
        cfg_arm = 1'b0;
        chk("arm_state", sts_state, 1);
        chk("arm_wrapped", sts_wrapped, 0);
        chk("arm_trig_addr", sts_trig_addr, 0);
    endtask

    // Issue one request and wait for its result, allowing at most 8 cycles.
    task automatic do_read(input string tag, input logic [DW-1:0] exp_d, input logic exp_l);
        int k;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        k = 0;
        while (rd_vld !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        chk({tag, "_vld"}, rd_vld, 1);
        chk({tag, "_data"}, rd_data, exp_d);
        chk({tag, "_last"}, rd_last, exp_l);
    endtask

    // A request that must be ignored: no RAM read and no rd_vld follow.
    task automatic no_read(input string tag);
        logic seen;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        seen = rd_vld | ram_rdb;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | rd_vld | ram_rdb;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        logic seen;

        // ---------------- reset
        tick();
        tick();
        chk("reset_outs", any_out, 0);
        rst_n = 1'b1;
        tick();
        chk("reset_state", sts_state, 0);

        // ---------------- 1: short capture, no wrap
        arm(12'd3);
        for (int i = 0; i < 10; i++) begin
            smp_vld  = 1'b1;
            smp_data = 16'(i);
            smp_trig = (i == 5);
            tick();
            if (i <= 8) begin
                chk("t1_wra", ram_wra, 1);
                chk("t1_addra", ram_addra, i);
                chk("t1_dina", ram_dina, i);
            end else begin
                chk("t1_no_write", ram_wra, 0);
            end
            if (i == 5) chk("t1_post", sts_state, 2);
            if (i == 8) chk("t1_done", sts_state, 3);
        end
        smp_vld  = 1'b0;
        smp_trig = 1'b0;
        chk("t1_trig_addr", sts_trig_addr, 5);
        chk("t1_wrapped", sts_wrapped, 0);

        // ---------------- 5: first read timing, and a request while busy
        rd_req = 1'b1;
        tick();                                   // N+1
        chk("t5_rdb", ram_rdb, 1);
        chk("t5_csb", ram_csb, 1);
        chk("t5_addrb", ram_addrb, 0);
        chk("t5_busy", rd_busy, 1);               // rd_req stays high here
        tick();                                   // N+2
        rd_req = 1'b0;
        chk("t5_rdb_single", ram_rdb, 0);
        chk("t5_vld_early", rd_vld, 0);
        tick();                                   // N+3
        chk("t5_vld", rd_vld, 1);
        chk("t5_data", rd_data, 0);
        chk("t5_last", rd_last, 0);
        chk("t5_busy_clr", rd_busy, 0);
        tick();                                   // N+4
        chk("t5_no_extra", rd_vld | ram_rdb, 0);
        chk("t5_data_hold", rd_data, 0);

        for (int j = 1; j < 9; j++) do_read("t1_rd", 16'(j), (j == 8));
        no_read("t1_rd_after_last");

        // ---------------- 2: wrapped capture
        arm(12'd100);
        for (int i = 0; i < 5000; i++) begin
            smp_vld  = 1'b1;
            smp_data = 16'(i);
            smp_trig = (i == 4500);
            tick();
            if (i == 0 || i == 4095 || i == 4096 || i == 4500 || i == 4600) begin
                chk("t2_wra", ram_wra, 1);
                chk("t2_addra", ram_addra, i % 4096);
            end
            if (i == 4095) chk("t2_wrapped_set", sts_wrapped, 1);
            if (i == 4601) chk("t2_no_write", ram_wra, 0);
        end
        smp_vld  = 1'b0;
        smp_trig = 1'b0;
        chk("t2_state", sts_state, 3);
        chk("t2_wrapped", sts_wrapped, 1);
        chk("t2_trig_addr", sts_trig_addr, 404);
        for (int j = 0; j < 4096; j++) do_read("t2_rd", 16'(505 + j), (j == 4095));
        no_read("t2_rd_after_last");

        // ---------------- 3: zero post length
        arm(12'd0);
        smp_vld  = 1'b1;
        smp_trig = 1'b1;
        smp_data = 16'hbeef;
        tick();
        smp_vld  = 1'b0;
        smp_trig = 1'b0;
        chk("t3_state", sts_state, 3);
        chk("t3_wra", ram_wra, 1);
        chk("t3_addra", ram_addra, 0);
        chk("t3_trig_addr", sts_trig_addr, 0);
        do_read("t3_rd", 16'hbeef, 1'b1);
        no_read("t3_rd_after_last");

        // ---------------- 4: abort during POST, abort beats arm
        arm(12'd10);
        for (int i = 0; i < 4; i++) begin
            smp_vld  = 1'b1;
            smp_data = 16'(i);
            smp_trig = (i == 1);
            tick();
        end
        smp_trig = 1'b0;
        chk("t4_post", sts_state, 2);
        cfg_abort = 1'b1;
        smp_data  = 16'd4;
        tick();
        cfg_abort = 1'b0;
        chk("t4_abort_state", sts_state, 0);
        chk("t4_abort_no_write", ram_wra, 0);
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | ram_wra;
        end
        smp_vld = 1'b0;
        chk("t4_idle_no_write", seen, 0);
        chk("t4_trig_kept", sts_trig_addr, 1);
        arm(12'd5);
        cfg_arm   = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_arm   = 1'b0;
        cfg_abort = 1'b0;
        chk("t4_abort_wins", sts_state, 0);

        // ---------------- 6: asynchronous reset mid-POST
        arm(12'd50);
        for (int i = 0; i < 10; i++) begin
            smp_vld  = 1'b1;
            smp_data = 16'(i + 1);
            smp_trig = (i == 2);
            tick();
        end
        smp_trig = 1'b0;
        chk("t6_post", sts_state, 2);
        chk("t6_writing", ram_wra, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outs", any_out, 0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | ram_wra;
        end
        smp_vld = 1'b0;
        chk("t6_no_write", seen, 0);
        chk("t6_idle", sts_state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_capture_ctrl.md
Name: dbg_capture_ctrl

Overview:
Capture sequencer for the 4096x16 1R1W debug RAM.
- Capture: writes a qualified ADC sample stream into the RAM as a circular pre-trigger buffer, accepts one trigger, writes a programmable number of post-trigger samples, then stops.
- Readout: streams the stored window out oldest-first, one sample per request, through the RAM read port.
- Position: sits between the ADC sample tap / debug register file and the RAM wrapper. It drives both RAM ports.

Parameters:
- RAM_DEPTH, 4096, words in the RAM; equals 2**ADDR_WIDTH.
- ADDR_WIDTH, 12, RAM address width.
- DATA_WIDTH, 16, sample width.
- READ_LATENCY, 1, RAM cycles from read command to valid ram_doutb.

Ports:
- clk  in  1  system clock; RAM ports run on clk.
- rst_n  in  1  asynchronous active-low reset.
- cfg_arm  in  1  pulse: restart capture.
- cfg_abort  in  1  pulse: return to IDLE.
- cfg_post_len  in  ADDR_WIDTH  post-trigger sample count; sampled at arm.
- smp_vld  in  1  sample qualifier.
- smp_data  in  DATA_WIDTH  sample.
- smp_trig  in  1  trigger; honoured only with smp_vld.
- sts_state  out  2  0=IDLE, 1=PRE, 2=POST, 3=DONE.
- sts_wrapped  out  1  write pointer wrapped at least once since arm.
- sts_trig_addr  out  ADDR_WIDTH  RAM address of the trigger sample.
- rd_req  in  1  pulse: fetch next stored sample.
- rd_busy  out  1  read outstanding.
- rd_vld  out  1  rd_data valid, one-cycle pulse.
- rd_data  out  DATA_WIDTH  read sample.
- rd_last  out  1  with rd_vld: final sample of the window.
- ram_csa, ram_wra  out  1  RAM write port select / write enable.
- ram_addra  out  ADDR_WIDTH  write address.
- ram_dina  out  DATA_WIDTH  write data.
- ram_csb, ram_rdb  out  1  RAM read port select / read enable.
- ram_addrb  out  ADDR_WIDTH  read address.
- ram_doutb  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset: all outputs 0; state IDLE; internal pointers, counters and flags cleared.
- Priority in a single cycle: cfg_abort > cfg_arm > sample and read activity.
  - cfg_abort, any state: IDLE next cycle; no writes are issued from that cycle on. The wrapped flag and trigger address are kept.
  - cfg_arm, any state: PRE next cycle; wr_ptr=0, wrapped=0, trig_addr=0; cfg_post_len latched; any outstanding read is dropped and no rd_vld is produced for it.
- Write path: every smp_vld in PRE or POST yields registered ram_csa=ram_wra=1, ram_addra=wr_ptr, ram_dina=smp_data on the next cycle.
  - wr_ptr then increments modulo RAM_DEPTH.
  - Going 4095->0 sets wrapped.
  - smp_vld in IDLE or DONE produces no write.
- PRE state:
  - smp_vld & smp_trig: the sample is written, trig_addr=wr_ptr, post_cnt=latched post_len.
  - Next state is POST, or DONE if post_len=0.
- POST state:
  - smp_trig is ignored.
  - Each smp_vld writes and decrements post_cnt.
  - The write that takes post_cnt from 1 to 0 moves the state to DONE.
- Stored window at DONE:
  - wrapped=0: start=0, count=wr_ptr.
  - wrapped=1: start=wr_ptr, count=RAM_DEPTH.
  - The count is an ADDR_WIDTH+1-bit value.
  - Readout resets to start on each entry to DONE.
- Readout (DONE only):
  - rd_req at cycle N with rd_busy=0 and samples remaining: rd_busy=1 from N+1; ram_csb=ram_rdb=1 and ram_addrb=rd_ptr at N+1 only.
  - rd_data is registered from ram_doutb, so rd_vld=1 at N+2+READ_LATENCY (N+3 by default). rd_busy clears in that same cycle.
  - rd_ptr increments modulo RAM_DEPTH.
  - rd_last=1 with the count-th sample.
- Ignored read requests: rd_req is ignored while rd_busy=1, outside DONE, or after rd_last has been delivered.
- Outputs between events: rd_vld and rd_last are single-cycle pulses; rd_data holds its value between pulses.

Test Plan:
1. post_len=3; arm; 10 samples with data=index; trig on index 5 -> writes to addr 0..8; DONE after index 8 is written; trig_addr=5; wrapped=0; 9 reads return 0..8; rd_last on the 9th; a 10th rd_req gives no rd_vld.
2. post_len=100; 5000 samples with data=index; trig at index 4500 -> last write index 4600 at addr 504; wrapped=1; 4096 reads return 505..4600; rd_last on the value 4600.
3. post_len=0; trig on the first valid sample -> DONE one cycle after that write; a single read returns the sample with rd_last=1.
4. cfg_abort during POST -> sts_state=0 the next cycle; no further ram_wra; cfg_abort with cfg_arm in the same cycle -> IDLE.
5. rd_req at cycle N -> ram_rdb at N+1 with addr=start, rd_vld at N+3; a rd_req at N+1 produces nothing extra.
6. rst_n low mid-POST with smp_vld active -> all outputs 0 immediately and state IDLE; samples after reset release produce no writes.
